// File: rtl/busca_pkg.sv
// busca_pkg: shared state encoding and PC step for the instruction fetch stage.
package busca_pkg;
    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        BUSCA    = 3'd1,
        PRONTO   = 3'd2,
        DESCARTE = 3'd3,
        ERRO     = 3'd4
    } estado_t;
    localparam logic [31:0] PASSO_PC = 32'd4;
endpackage

// File: rtl/somador32.sv
// somador32: plain adder, carry-out discarded so results wrap modulo 2^LARGURA.
module somador32 #(
    parameter int LARGURA = 32
) (
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    output logic [LARGURA-1:0] soma
);
    assign soma = a + b;
endmodule

// File: rtl/busca_instrucao.sv
// busca_instrucao: fetches one instruction per PC, holds it until consumed,
// handles redirect (flush) and traps misaligned PCs in a sticky error state.
module busca_instrucao
    import busca_pkg::*;
#(
    parameter int LARGURA = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LARGURA-1:0] atual_Pc,
    output logic               stall_Pc,
    input  logic               flush,
    input  logic               consumo,
    output logic               mem_req,
    output logic [LARGURA-1:0] mem_addr,
    input  logic               mem_ack,
    input  logic [LARGURA-1:0] mem_rdata,
    output logic [LARGURA-1:0] instrucao,
    output logic               instr_valida,
    output logic [LARGURA-1:0] instr_pc,
    output logic [LARGURA-1:0] pc_mais4,
    output logic               erro_alinhamento
);
    estado_t estado, prox;
    logic captura_pc, captura_instr;
    always_comb begin
        prox          = estado;
        captura_pc    = 1'b0;
        captura_instr = 1'b0;
        case (estado)
            OCIOSO: if (!flush) begin
                prox       = (atual_Pc[1:0] == 2'b00) ? BUSCA : ERRO;
                captura_pc = (atual_Pc[1:0] == 2'b00);
            end
            BUSCA: if (flush) begin
                prox = mem_ack ? OCIOSO : DESCARTE;
            end else if (mem_ack) begin
                prox          = PRONTO;
                captura_instr = 1'b1;
            end
            PRONTO:   prox = (flush || consumo) ? OCIOSO : PRONTO;
            // The memory still owes a response; wait for it and throw it away.
            DESCARTE: prox = mem_ack ? OCIOSO : DESCARTE;
            ERRO:     prox = flush ? OCIOSO : ERRO;
            default:  prox = OCIOSO;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado    <= OCIOSO;
            instrucao <= '0;
            instr_pc  <= '0;
        end else begin
            estado <= prox;
            if (captura_pc) instr_pc <= atual_Pc;
            if (captura_instr) instrucao <= mem_rdata;
        end
    end
    assign mem_req          = (estado == BUSCA) || (estado == DESCARTE);
    assign mem_addr         = instr_pc;
    assign instr_valida     = (estado == PRONTO);
    assign erro_alinhamento = (estado == ERRO);
    assign stall_Pc         = !(((estado == PRONTO) && consumo) || flush);
    somador32 #(.LARGURA(LARGURA)) u_somador (
        .a    (instr_pc),
        .b    (LARGURA'(PASSO_PC)),
        .soma (pc_mais4)
    );
endmodule

// File: tb/tb_busca_instrucao.sv
// tb_busca_instrucao: directed scenarios plus random traffic checked against
// a transaction-level model of the fetch stage.
module tb_busca_instrucao;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] atual_Pc = '0;
    logic        flush = 1'b0, consumo = 1'b0, mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall_Pc, mem_req, instr_valida, erro_alinhamento;
    logic [31:0] mem_addr, instrucao, instr_pc, pc_mais4;

    busca_instrucao dut (
        .clk(clk), .rst(rst), .atual_Pc(atual_Pc), .stall_Pc(stall_Pc),
        .flush(flush), .consumo(consumo), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instrucao(instrucao),
        .instr_valida(instr_valida), .instr_pc(instr_pc), .pc_mais4(pc_mais4),
        .erro_alinhamento(erro_alinhamento)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a request is outstanding (busy), possibly doomed (drop);
    // a word is held (valid); or the stage is trapped (err).
    logic        m_valid, m_err, m_busy, m_drop;
    logic [31:0] m_pc, m_instr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_err = 0; m_busy = 0; m_drop = 0; m_pc = '0; m_instr = '0;
    endtask

    task automatic model_step();
        if (m_err) begin
            if (flush) m_err = 0;
        end else if (m_valid) begin
            if (flush || consumo) m_valid = 0;
        end else if (m_busy) begin
            if (mem_ack) begin
                m_busy = 0;
                if (!m_drop && !flush) begin
                    m_valid = 1;
                    m_instr = mem_rdata;
                end
                m_drop = 0;
            end else if (flush) m_drop = 1;
        end else if (!flush) begin
            if (atual_Pc % 4 != 0) m_err = 1;
            else begin
                m_pc   = atual_Pc;
                m_busy = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("stall_Pc", 32'(stall_Pc), 32'(!((m_valid && consumo) || flush)));
        chk("mem_req", 32'(mem_req), 32'(m_busy));
        if (m_busy) chk("mem_addr", mem_addr, m_pc);
        chk("instr_valida", 32'(instr_valida), 32'(m_valid));
        chk("instrucao", instrucao, m_instr);
        chk("instr_pc", instr_pc, m_pc);
        chk("pc_mais4", pc_mais4, m_pc + 32'd4);
        chk("erro", 32'(erro_alinhamento), 32'(m_err));
    endtask

    task automatic set_in(input logic f, input logic c, input logic a,
                          input logic [31:0] d, input logic [31:0] p);
        flush = f; consumo = c; mem_ack = a; mem_rdata = d; atual_Pc = p;
    endtask

    task automatic step();
        #1 check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cyc(input logic f, input logic c, input logic a,
                       input logic [31:0] d, input logic [31:0] p);
        set_in(f, c, a, d, p);
        step();
    endtask

    initial begin
        model_reset();
        #2 check_all();
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;
        model_reset();
        // first-cycle-after-reset behaviour was exercised by the edge above with idle inputs:
        // restart cleanly so the directed fetch starts from OCIOSO
        rst = 1'b0; #1; rst = 1'b1; #1;

        // Basic fetch at PC 0, ack one cycle after the request appears
        cyc(0, 1, 0, 32'h0, 32'h0);
        cyc(0, 1, 0, 32'h0, 32'h0);
        cyc(0, 1, 1, 32'h00500093, 32'h0);
        set_in(0, 1, 0, 32'h0, 32'h4);
        #1;
        chk("r35_instr", instrucao, 32'h00500093);
        chk("r35_pc", instr_pc, 32'h0);
        chk("r35_pc4", pc_mais4, 32'h4);
        chk("r35_stall", 32'(stall_Pc), 32'd0);
        step();
        chk("r35_stall_after", 32'(stall_Pc), 32'd1);

        // Hold in PRONTO for 5 cycles, stray acks ignored
        cyc(0, 0, 0, 32'h0, 32'h4);
        cyc(0, 0, 1, 32'h11, 32'h4);
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, i[0], 32'hBAD0 + i, 32'h8);
            #1;
            chk("r36_instr", instrucao, 32'h11);
            chk("r36_stall", 32'(stall_Pc), 32'd1);
            chk("r36_req", 32'(mem_req), 32'd0);
            step();
        end
        cyc(0, 1, 0, 32'h0, 32'h8);

        // Misaligned PC traps until flush
        cyc(0, 0, 0, 32'h0, 32'h6);
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 1, 32'h0, 32'h6);
            #1;
            chk("r37_erro", 32'(erro_alinhamento), 32'd1);
            chk("r37_req", 32'(mem_req), 32'd0);
            step();
        end
        cyc(1, 0, 0, 32'h0, 32'h8);
        chk("r37_cleared", 32'(erro_alinhamento), 32'd0);

        // Flush during fetch; late data is dropped and next fetch uses new PC
        cyc(0, 0, 0, 32'h0, 32'h8);
        cyc(1, 0, 0, 32'h0, 32'h40);
        cyc(0, 0, 0, 32'h0, 32'h40);
        cyc(0, 0, 0, 32'h0, 32'h40);
        cyc(0, 1, 1, 32'hDEADBEEF, 32'h40);
        chk("r38_valid", 32'(instr_valida), 32'd0);
        cyc(0, 0, 0, 32'h0, 32'h40);
        chk("r38_newpc", instr_pc, 32'h40);
        chk("r38_addr", mem_addr, 32'h40);
        cyc(0, 1, 1, 32'h22, 32'h44);
        cyc(0, 1, 0, 32'h0, 32'h44);

        // Top-of-address-space wrap
        cyc(0, 0, 0, 32'h0, 32'hFFFFFFFC);
        chk("r39_pc4", pc_mais4, 32'h0);

        // Asynchronous reset mid-request, then a stray ack after release
        rst = 1'b0;
        #2;
        model_reset();
        chk("r40_req", 32'(mem_req), 32'd0);
        chk("r40_pc", instr_pc, 32'h0);
        check_all();
        @(negedge clk);
        set_in(0, 0, 1, 32'h33, 32'h100);
        rst = 1'b1;
        step();
        chk("r40_fetch", instr_pc, 32'h100);
        chk("r40_notvalid", 32'(instr_valida), 32'd0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] p;
            p = {$urandom_range(0, 255), 2'b00};
            if ($urandom_range(0, 15) == 0) p[1:0] = 2'($urandom_range(1, 3));
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) == 0, $urandom, p);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/busca_instrucao.md
BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 SHALL have parameter LARGURA, default 32, datapath width of PC, address and instruction.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port atual_Pc  input  32  current PC from the pc register.
REQ-005 SHALL have port stall_Pc  output  1  high = pc register must hold its value.
REQ-006 SHALL have port flush  input  1  redirect; discard any in-flight or held instruction.
REQ-007 SHALL have port consumo  input  1  downstream accepts instrucao this cycle.
REQ-008 SHALL have port mem_req  output  1  instruction-memory read request.
REQ-009 SHALL have port mem_addr  output  32  read address, word-aligned.
REQ-010 SHALL have port mem_ack  input  1  single-cycle pulse: mem_rdata valid.
REQ-011 SHALL have port mem_rdata  input  32  fetched word.
REQ-012 SHALL have port instrucao  output  32  held instruction.
REQ-013 SHALL have port instr_valida  output  1  instrucao/instr_pc valid.
REQ-014 SHALL have port instr_pc  output  32  address of instrucao.
REQ-015 SHALL have port pc_mais4  output  32  instr_pc + 4.
REQ-016 SHALL have port erro_alinhamento  output  1  misaligned PC fault, sticky.

Function
REQ-017 SHALL implement FSM states OCIOSO, BUSCA, PRONTO, DESCARTE, ERRO.
REQ-018 OCIOSO: atual_Pc[1:0]==0 -> capture atual_Pc into instr_pc, go BUSCA; else go ERRO.
REQ-019 BUSCA: mem_req=1, mem_addr=instr_pc held constant until mem_ack; mem_ack in the first BUSCA cycle is legal.
REQ-020 BUSCA with mem_ack and no flush: register mem_rdata into instrucao, go PRONTO; instr_valida=1 from the next cycle (minimum 2 cycles OCIOSO-to-valid).
REQ-021 PRONTO: hold instrucao/instr_pc stable while consumo=0; on consumo=1 go OCIOSO, instr_valida=0 next cycle.
REQ-022 stall_Pc SHALL equal NOT((PRONTO AND consumo) OR flush), combinationally; PC advances exactly once per consumed instruction.
REQ-023 flush SHALL take priority over consumo and mem_ack in every state.
REQ-024 flush in BUSCA without mem_ack -> DESCARTE; DESCARTE keeps mem_req/mem_addr until mem_ack, drops data, then goes OCIOSO.
REQ-025 flush in BUSCA with mem_ack same cycle -> data dropped, go OCIOSO.
REQ-026 flush in PRONTO or ERRO -> OCIOSO, instr_valida and erro_alinhamento cleared next cycle.
REQ-027 ERRO: erro_alinhamento=1, mem_req=0, instr_valida=0, stay until flush or reset.
REQ-028 pc_mais4 SHALL be instr_pc+4 modulo 2^32 (0xFFFFFFFC -> 0x00000000), combinational.
REQ-029 mem_ack outside BUSCA/DESCARTE SHALL be ignored.

Reset
REQ-030 rst low SHALL immediately force state OCIOSO, instrucao=0, instr_pc=0, instr_valida=0, erro_alinhamento=0, mem_req=0, independent of clk.
REQ-031 Reset mid-request SHALL abandon the transaction; a late mem_ack after release is ignored per REQ-029.
REQ-032 First fetch SHALL start in the first OCIOSO cycle after rst deasserts.

Structure
REQ-033 Package busca_pkg SHALL hold the state encoding (3-bit) and the constant PASSO_PC=4.
REQ-034 The +4 adder SHALL be a sub-module somador32 (32-bit, carry-out discarded).

Verification
REQ-035 Reset, atual_Pc=0x00000000, mem_ack 1 cycle after req, rdata=0x00500093, consumo=1 -> instrucao=0x00500093, instr_pc=0, pc_mais4=4, stall_Pc low one cycle.
REQ-036 consumo=0 for 5 cycles in PRONTO -> instrucao stable, stall_Pc=1 throughout, mem_req=0.
REQ-037 atual_Pc=0x00000006 -> ERRO, erro_alinhamento=1, mem_req never asserted; flush -> cleared next cycle.
REQ-038 flush in BUSCA, mem_ack 3 cycles later with 0xDEADBEEF -> never valid; next fetch uses new atual_Pc=0x00000040.
REQ-039 instr_pc=0xFFFFFFFC -> pc_mais4=0x00000000.
REQ-040 rst low mid-BUSCA -> all outputs at reset values before next clk edge; stray mem_ack ignored.
